lm07_spi_resp: RTL and testbench
================================

Name: lm07_spi_resp

Overview:
- Behavioural/synthesisable SPI responder (slave transmitter) that models the LM07 temperature sensor's serial output for the continuous LM07 SPI reader.
- Oversamples CS and SCK on its own SYSCLK, shifts a temperature word out on SIO MSB-first, and changes SIO on SCK falling edges so the reader can sample on rising edges.
- Used in the testbench in place of the sensor, and on-chip as a loopback source.

Parameters:
- DATA_W, 8, bits per frame shifted out on SIO.
- RESET_TEMP, 8'h00, holding-register value after reset (width DATA_W).

Ports:
- SYSCLK  input  1  responder clock. Must be fast enough that SCK high and low phases each last at least 2 SYSCLK periods.
- RSTN  input  1  reset, asynchronous and active-low.
- CS  input  1  chip select from reader, active-low, asynchronous to SYSCLK.
- SCK  input  1  SPI clock from reader, idles low, asynchronous to SYSCLK.
- SIO  output  1  serial data to reader.
- temp_in  input  DATA_W  temperature value to publish.
- temp_load  input  1  single-cycle strobe; captures temp_in into holding register.
- busy  output  1  high while a frame is in progress (CS synchronised low).
- frame_done  output  1  one-cycle pulse: frame completed with all DATA_W bits sampled.
- frame_abort  output  1  one-cycle pulse: CS rose before DATA_W rising SCK edges.

Behaviour:
- Synchronisers: CS and SCK each pass through a 2-flop synchroniser plus one history flop. Edge detects come from the last two stages. CS fall/rise and SCK rise/fall are therefore recognised 3 SYSCLK after the pin event.
- Holding register hold_r:
  - Resets to RESET_TEMP.
  - Loads temp_in on temp_load in any state.
  - A load during a frame affects only the next frame.
- Shift register sh_r (DATA_W): loaded from hold_r on CS-fall detect. If temp_load fires in the same cycle, the old hold_r value is used.
- SIO = sh_r[DATA_W-1] in SHIFT; 0 in IDLE and TAIL (see Optional Feature).
- Bit counter bit_cnt, width $clog2(DATA_W+1):
  - Cleared on CS-fall detect.
  - Increments on each SCK-rise detect in SHIFT.
  - Saturates at DATA_W.
- States:
  - IDLE: busy=0, SIO=0. On CS-fall detect: load sh_r, clear bit_cnt, go to SHIFT.
  - SHIFT: busy=1.
    - On SCK-fall detect with bit_cnt<DATA_W: sh_r shifts left by one, 0 in at LSB.
    - On SCK-fall detect with bit_cnt==DATA_W: go to TAIL.
  - TAIL: busy=1, SIO=0. Extra SCK edges are ignored.
- CS-rise detect in SHIFT or TAIL:
  - Return to IDLE.
  - If bit_cnt==DATA_W, pulse frame_done; otherwise pulse frame_abort.
  - The pulse occurs in the same cycle as the transition.
- CS-rise detect in IDLE: ignored.
- Simultaneous CS-rise and SCK edge detect: CS-rise wins, and the SCK edge is discarded.
- Required reader timing:
  - First SCK rise ≥ 4 SYSCLK after CS fall.
  - Each SCK fall must occur ≥ 4 SYSCLK before the next SCK rise, so SIO settles before sampling.
- Reset (any time, including mid-frame):
  - Outputs: SIO=0, busy=0, frame_done=0, frame_abort=0.
  - State IDLE, sh_r=0, bit_cnt=0, hold_r=RESET_TEMP, synchronisers cleared to 1 for CS and 0 for SCK.
  - After RSTN deasserts with CS already low, no frame starts until CS goes high and falls again.

Optional Feature:
- Macro: LM07_SPI_RESP_TRISTATE_EN.
- Defined: SIO is 1'bz whenever the FSM is in IDLE, which allows several responders on a shared SIO line. SHIFT and TAIL behaviour is unchanged.
- Undefined: SIO is driven 0 in IDLE, with no high-impedance state.

Test Plan:
- Reset then temp_load with 8'hA5, one 8-SCK frame -> reader captures 8'hA5; frame_done pulses once; busy high for the whole frame.
- Load 8'h3C, frame, then load 8'hC3 during the frame's 4th bit -> first frame captures 8'h3C, second frame captures 8'hC3.
- CS deasserted after 3 SCK rises with 8'hF0 loaded -> frame_abort pulses, frame_done stays 0, busy drops; next full frame returns 8'hF0.
- 9 SCK cycles in one frame with 8'hA5 -> bits 1..8 match 8'hA5, 9th sampled bit is 0 (TAIL), and frame_done pulses.
- RSTN asserted mid-frame after 5 bits -> SIO=0 and busy=0 immediately, then hold_r=RESET_TEMP; the following frame returns RESET_TEMP.
- With LM07_SPI_RESP_TRISTATE_EN defined -> SIO is z in IDLE and driven in SHIFT. Without it -> SIO is 0 in IDLE.

Source files
------------

// File: rtl/lm07_spi_resp.sv
// LM07-style SPI responder: oversamples CS/SCK on SYSCLK and shifts a held temperature word out on SIO, MSB first.
// Define LM07_SPI_RESP_TRISTATE_EN to float SIO while idle so several responders can share one line.
module lm07_spi_resp #(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] RESET_TEMP = '0
) (
    input  logic              SYSCLK,
    input  logic              RSTN,
    input  logic              CS,
    input  logic              SCK,
    output logic              SIO,
    input  logic [DATA_W-1:0] temp_in,
    input  logic              temp_load,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_abort
);

    localparam int                CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DATA_W);
    // Bit 0 is CS (idles high), bit 1 is SCK (idles low).
    localparam logic [1:0]        SYNC_INIT = 2'b01;

    typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

    state_t            state_r;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] sh_r;
    logic [CNT_W-1:0]  bit_cnt;
    logic [1:0]        pin_in;
    logic [1:0]        meta_r;
    logic [1:0]        sync_r;
    logic [1:0]        hist_r;
    logic [1:0]        flush_cnt;
    logic              armed_r;
    logic              cs_fall;
    logic              cs_rise;
    logic              sck_rise;
    logic              sck_fall;

    assign pin_in = {SCK, CS};

    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            meta_r <= SYNC_INIT;
            sync_r <= SYNC_INIT;
            hist_r <= SYNC_INIT;
        end else begin
            meta_r <= pin_in;
            sync_r <= meta_r;
            hist_r <= sync_r;
        end
    end

    assign cs_fall  =  hist_r[0] & ~sync_r[0];
    assign cs_rise  = ~hist_r[0] &  sync_r[0];
    assign sck_rise = ~hist_r[1] &  sync_r[1];
    assign sck_fall =  hist_r[1] & ~sync_r[1];

    // A frame may only start once CS has been seen high with real samples
    // after reset, so a CS held low across reset never starts a frame.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            flush_cnt <= 2'd0;
            armed_r   <= 1'b0;
        end else begin
            if (flush_cnt != 2'd2) begin
                flush_cnt <= flush_cnt + 2'd1;
            end
            if (flush_cnt == 2'd2 && sync_r[0]) begin
                armed_r <= 1'b1;
            end
        end
    end

    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r     <= IDLE;
            hold_r      <= RESET_TEMP;
            sh_r        <= '0;
            bit_cnt     <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            if (temp_load) begin
                hold_r <= temp_in;
            end
            case (state_r)
                IDLE: begin
                    if (cs_fall && armed_r) begin
                        sh_r    <= hold_r;
                        bit_cnt <= '0;
                        state_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    // CS rising wins over any simultaneous SCK edge.
                    if (cs_rise) begin
                        state_r     <= IDLE;
                        frame_done  <= (bit_cnt == FULL);
                        frame_abort <= (bit_cnt != FULL);
                    end else if (sck_rise) begin
                        if (bit_cnt != FULL) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt == FULL) begin
                            state_r <= TAIL;
                        end else begin
                            sh_r <= {sh_r[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                TAIL: begin
                    if (cs_rise) begin
                        state_r     <= IDLE;
                        frame_done  <= (bit_cnt == FULL);
                        frame_abort <= (bit_cnt != FULL);
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign busy = (state_r != IDLE);

`ifdef LM07_SPI_RESP_TRISTATE_EN
    assign SIO = (state_r == IDLE)  ? 1'bz :
                 (state_r == SHIFT) ? sh_r[DATA_W-1] : 1'b0;
`else
    assign SIO = (state_r == SHIFT) ? sh_r[DATA_W-1] : 1'b0;
`endif

endmodule

// File: tb/tb_lm07_spi_resp.sv
// Directed bench for lm07_spi_resp: acts as the SPI reader and checks captured words and status pulses.
module tb_lm07_spi_resp;

    logic       SYSCLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       CS = 1'b1;
    logic       SCK = 1'b0;
    logic [7:0] temp_in = 8'h00;
    logic       temp_load = 1'b0;
    wire        SIO;
    logic       busy;
    logic       frame_done;
    logic       frame_abort;

    int n_pass = 0;
    int n_checks = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    lm07_spi_resp #(
        .DATA_W     (8),
        .RESET_TEMP (8'h5C)
    ) dut (
        .SYSCLK      (SYSCLK),
        .RSTN        (RSTN),
        .CS          (CS),
        .SCK         (SCK),
        .SIO         (SIO),
        .temp_in     (temp_in),
        .temp_load   (temp_load),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always #5 SYSCLK = ~SYSCLK;

    always @(negedge SYSCLK) begin
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
    end

`ifdef LM07_SPI_RESP_TRISTATE_EN
    localparam logic SIO_IDLE = 1'bz;
`else
    localparam logic SIO_IDLE = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge SYSCLK);
        #3;
    endtask

    task automatic load(input logic [7:0] v);
        temp_in   = v;
        temp_load = 1'b1;
        wait_clk(1);
        temp_load = 1'b0;
    endtask

    task automatic cs_low();
        CS = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_high();
        CS = 1'b1;
        wait_clk(6);
    endtask

    // Reader samples SIO on the SCK rising edge.
    task automatic sck_bit(output logic b);
        SCK = 1'b1;
        b = SIO;
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        wait_clk(6);
        SCK = 1'b0;
        wait_clk(6);
    endtask

    task automatic frame(input int nbits, output logic [15:0] data);
        logic b;
        data = 16'h0000;
        cs_low();
        for (int i = 0; i < nbits; i++) begin
            sck_bit(b);
            data = {data[14:0], b};
        end
        cs_high();
        $display("frame: bits=%0d captured=0x%0h done_cnt=%0d abort_cnt=%0d", nbits, data, done_cnt, abort_cnt);
    endtask

    initial begin
        logic [15:0] data;
        logic        b;
        int          d0;
        int          a0;

        // Reset state
        wait_clk(3);
        check("rst_sio",   {31'd0, SIO}, {31'd0, SIO_IDLE});
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, frame_done}, 32'd0);
        check("rst_abort", {31'd0, frame_abort}, 32'd0);
        RSTN = 1'b1;
        wait_clk(5);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Plain 8-bit frame
        load(8'hA5);
        d0 = done_cnt; a0 = abort_cnt;
        frame(8, data);
        check("f1_data",  {16'd0, data}, 32'h0000_00A5);
        check("f1_done",  done_cnt - d0, 32'd1);
        check("f1_abort", abort_cnt - a0, 32'd0);
        check("f1_busy_after", {31'd0, busy}, 32'd0);
        check("f1_sio_idle", {31'd0, SIO}, {31'd0, SIO_IDLE});

        // Load during a frame only affects the next frame
        load(8'h3C);
        data = 16'h0000;
        cs_low();
        for (int i = 0; i < 8; i++) begin
            sck_bit(b);
            data = {data[14:0], b};
            if (i == 3) load(8'hC3);
        end
        cs_high();
        $display("frame: bits=8 captured=0x%0h (load mid-frame)", data);
        check("f2_data", {16'd0, data}, 32'h0000_003C);
        frame(8, data);
        check("f3_data", {16'd0, data}, 32'h0000_00C3);

        // Abort after 3 bits, then full frame of the same word
        load(8'hF0);
        d0 = done_cnt; a0 = abort_cnt;
        frame(3, data);
        check("f4_bits",  {16'd0, data}, 32'h0000_0007);
        check("f4_abort", abort_cnt - a0, 32'd1);
        check("f4_done",  done_cnt - d0, 32'd0);
        check("f4_busy",  {31'd0, busy}, 32'd0);
        frame(8, data);
        check("f5_data", {16'd0, data}, 32'h0000_00F0);

        // Nine clocks: ninth bit comes from TAIL as 0
        load(8'hA5);
        d0 = done_cnt; a0 = abort_cnt;
        frame(9, data);
        check("f6_data",  {16'd0, data}, 32'h0000_014A);
        check("f6_done",  done_cnt - d0, 32'd1);
        check("f6_abort", abort_cnt - a0, 32'd0);

        // Reset mid-frame after 5 bits, CS still low across reset release
        load(8'h96);
        data = 16'h0000;
        cs_low();
        for (int i = 0; i < 5; i++) begin
            sck_bit(b);
            data = {data[14:0], b};
        end
        check("f7_bits", {16'd0, data}, 32'h0000_0012);
        RSTN = 1'b0;
        #1;
        check("mid_rst_sio",  {31'd0, SIO}, {31'd0, SIO_IDLE});
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        $display("reset asserted mid-frame after 5 bits");
        wait_clk(3);
        RSTN = 1'b1;
        wait_clk(10);
        check("cs_low_no_start", {31'd0, busy}, 32'd0);
        check("cs_low_sio",      {31'd0, SIO}, {31'd0, SIO_IDLE});
        cs_high();
        d0 = done_cnt;
        frame(8, data);
        check("f8_reset_temp", {16'd0, data}, 32'h0000_005C);
        check("f8_done", done_cnt - d0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
